avalon_st_checker: RTL and testbench
====================================

# avalon_st_checker

Avalon-ST sink that consumes the 16-bit ramp stream produced by the team's Avalon-ST ramp generator and checks it beat by beat. It counts received bytes, mismatching beats and run cycles, and records the first failing beat index. Optional pseudo-random backpressure exercises the source's ready handling. Control and status go through a 32-bit Avalon-MM slave; the block sits directly downstream of the generator in the loopback/test datapath.

## Interface
- `DATA_W`, 256: stream width in bits; multiple of 16. `NL = DATA_W/16` lanes; `NB = DATA_W/8` bytes per beat.
- Clock `csi_clk_clk` and reset `rsi_reset_reset_n` (synchronous, active-low) come first; the ports are listed below.
- `csi_clk_clk` in 1: single clock for all logic.
- `rsi_reset_reset_n` in 1: synchronous, active-low reset.
- `avs_ctrl_address` in 4: word address.
- `avs_ctrl_read` in 1: read strobe.
- `avs_ctrl_write` in 1: write strobe.
- `avs_ctrl_readdata` out 32: registered read data.
- `avs_ctrl_writedata` in 32: write data.
- `asi_data_data` in DATA_W: beat; lane i is `[16i+15:16i]`.
- `asi_data_valid` in 1: source valid.
- `asi_data_ready` out 1: sink ready.

## Operation
- Register map:
  - 0 ID `0xa51579e3` (RO).
  - 1 version `0x00000100` (RO).
  - 2 `0` (RO).
  - 3 scratch (RW).
  - 4 status (RO): bit0 running, bit1 done, bit2 error (sticky).
  - 5 control (WO, self-clearing pulse): bit0 start, bit1 clear.
  - 6 throttle (RW): bit0 enable.
  - 8 target bytes (RW).
  - 9 received bytes.
  - 10 error beats.
  - 11 first error beat index.
  - 12 run cycles.
  - Any other address reads `0xdeadbeef`.
- State machine with states IDLE, RUN, DONE:
  - IDLE/DONE -> RUN on start. At the same edge, all counters clear and the first-error index is set to `0xFFFFFFFF`.
  - Start while in RUN is ignored.
  - RUN -> DONE on the edge where an accepted beat makes received ≥ target.
  - With target 0, RUN -> DONE on the first RUN cycle even if no beat is accepted.
  - Clear from any state -> IDLE. Clear also resets the counters, the sticky error and the first-error index (`0xFFFFFFFF`).
  - If start and clear are written together, clear wins.
- Check rule for accepted beat n (n counts from 0 per run):
  - Expected lane i = `(n*NL + i) mod 2^16`.
  - A beat is an error if any lane mismatches.
  - Expected values derive from the beat index, not from received data, so a single corrupt beat does not cascade.
- Counter arithmetic:
  - Received bytes += NB per accepted beat, 32-bit wrap.
  - Error beats saturate at `0xFFFFFFFF`.
  - First error index is written only while it holds `0xFFFFFFFF`.
  - Run cycles increment every RUN cycle, 32-bit wrap.
- Ready generation:
  - `asi_data_ready = (state==RUN) && (!throttle_en || lfsr[0])`.
  - Ready never depends on valid.
  - Data presented outside RUN is never accepted.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed `0xACE1`. It advances every cycle and is re-seeded on reset and on start.

## Timing
- Reset values:
  - `asi_data_ready` 0, `avs_ctrl_readdata` 0, state IDLE.
  - Scratch, target, throttle and all counters 0.
  - First error index `0xFFFFFFFF`, LFSR `0xACE1`.
- Reset mid-run takes effect at the next edge and restores all of the above.
- Control writes take effect at the edge after the write. Start written in cycle t gives RUN and possible ready in cycle t+1.
- Acceptance happens at an edge where valid && ready. The counters update at that same edge.
- Ready is 0 in the cycle after the final accepted beat.
- Read latency is 1 cycle: readdata is valid in the cycle after address/read is presented. readdata is updated every cycle regardless of the read strobe.
- Run cycles equal the number of cycles spent in RUN, including the cycle of the final acceptance. With no throttle and valid held high, this equals the number of beats.

## Structure
- Package `avalon_st_check_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `ID_WORD` and `VERSION_WORD`;
  - register address localparams;
  - LFSR seed and tap constants.
- Sub-module `lfsr16`:
  - ports: clock, reset_n, reseed, out[15:0];
  - used for throttling.
- Lane comparison, counters and the register file live in the top level.

## Test plan
All scenarios use `DATA_W=256`: NL=16, NB=32.
- Register reset check: after reset, read addr 0/1/9/11/7 -> `0xa51579e3`, `0x100`, `0`, `0xFFFFFFFF`, `0xdeadbeef`. Scratch write `0x12345678` reads back.
- Clean run: target `0x400`, start, ideal ramp source with valid always high.
  - ready is high for exactly 32 cycles.
  - Status then reads `0b010`; received `0x400`, errors 0, first error `0xFFFFFFFF`, cycles 32.
- Corruption: same run with lane 3 of beat 5 XOR `0x0001`.
  - errors 1, first error 5, status `0b110`.
  - Beats 6..31 pass.
- Throttle: enable throttle and repeat the clean run.
  - Counts are identical; cycles > 32.
  - ready is never high outside RUN, and no beat is accepted while ready is 0.
- Control edge cases:
  - A start written mid-run has no effect.
  - Clear mid-run: IDLE and ready low the next cycle, all counters 0.
  - Target 0 plus start -> DONE after one cycle, received 0.
  - Reset asserted mid-run: all registers at reset values after one edge.
- Wrap-around: target 131104 (4097 beats); sample values wrap `0xFFFF` -> `0x0000` at beat 4096.
  - errors 0, received 131104.

Source files
------------

// File: rtl/avalon_st_check_pkg.sv
// Shared types and constants for the Avalon-ST ramp checker.
package avalon_st_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ID_WORD       = 32'ha51579e3;
    localparam logic [31:0] VERSION_WORD  = 32'h00000100;
    localparam logic [31:0] BAD_ADDR_WORD = 32'hdeadbeef;

    localparam logic [3:0] ADDR_ID         = 4'd0;
    localparam logic [3:0] ADDR_VERSION    = 4'd1;
    localparam logic [3:0] ADDR_ZERO       = 4'd2;
    localparam logic [3:0] ADDR_SCRATCH    = 4'd3;
    localparam logic [3:0] ADDR_STATUS     = 4'd4;
    localparam logic [3:0] ADDR_CONTROL    = 4'd5;
    localparam logic [3:0] ADDR_THROTTLE   = 4'd6;
    localparam logic [3:0] ADDR_TARGET     = 4'd8;
    localparam logic [3:0] ADDR_RX_BYTES   = 4'd9;
    localparam logic [3:0] ADDR_ERR_BEATS  = 4'd10;
    localparam logic [3:0] ADDR_FIRST_ERR  = 4'd11;
    localparam logic [3:0] ADDR_RUN_CYCLES = 4'd12;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR used to pace sink backpressure.
module lfsr16
    import avalon_st_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reseed,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (!reset_n || reseed) begin
            out <= LFSR_SEED;
        end else begin
            out <= lfsr_step(out);
        end
    end

endmodule

// File: rtl/avalon_st_checker.sv
// Avalon-ST sink that checks an incrementing 16-bit ramp beat by beat,
// with run statistics and control exposed on a 32-bit Avalon-MM slave.
module avalon_st_checker
    import avalon_st_check_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic              csi_clk_clk,
    input  logic              rsi_reset_reset_n,
    input  logic [3:0]        avs_ctrl_address,
    input  logic              avs_ctrl_read,
    input  logic              avs_ctrl_write,
    output logic [31:0]       avs_ctrl_readdata,
    input  logic [31:0]       avs_ctrl_writedata,
    input  logic [DATA_W-1:0] asi_data_data,
    input  logic              asi_data_valid,
    output logic              asi_data_ready
);

    localparam int NL = DATA_W / 16;
    localparam int NB = DATA_W / 8;

    state_t      state;
    logic [31:0] scratch;
    logic [31:0] target;
    logic        throttle_en;
    logic [31:0] rx_bytes;
    logic [31:0] err_beats;
    logic [31:0] first_err;
    logic [31:0] run_cycles;
    logic [31:0] beat_idx;
    logic        error_flag;

    logic [15:0] lfsr_out;
    logic        wr_ctrl;
    logic        start;
    logic        clear;
    logic        start_eff;
    logic        accept;
    logic        beat_bad;
    logic [15:0] lane_base;
    logic [31:0] rx_next;
    logic        done_now;
    logic [31:0] rd_mux;

    // Readdata is refreshed every cycle, so the read strobe carries no information.
    logic unused_read;
    logic unused_lfsr_bits;
    assign unused_read      = avs_ctrl_read;
    assign unused_lfsr_bits = ^lfsr_out[15:1];

    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CONTROL);
    assign start     = wr_ctrl && avs_ctrl_writedata[0];
    assign clear     = wr_ctrl && avs_ctrl_writedata[1];
    assign start_eff = start && !clear && (state != RUN);

    assign asi_data_ready = (state == RUN) && (!throttle_en || lfsr_out[0]);
    assign accept         = asi_data_valid && asi_data_ready;
    assign rx_next        = rx_bytes + 32'(NB);
    assign done_now       = (target == '0) || (accept && (rx_next >= target));

    lfsr16 u_lfsr (
        .clk     (csi_clk_clk),
        .reset_n (rsi_reset_reset_n),
        .reseed  (start_eff),
        .out     (lfsr_out)
    );

    // Expected lanes come from the beat index so one corrupt beat cannot cascade.
    always_comb begin
        lane_base = 16'(beat_idx * 32'(NL));
        beat_bad  = 1'b0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (asi_data_data[16*i +: 16] != (lane_base + 16'(i))) begin
                beat_bad = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = BAD_ADDR_WORD;
        case (avs_ctrl_address)
            ADDR_ID:         rd_mux = ID_WORD;
            ADDR_VERSION:    rd_mux = VERSION_WORD;
            ADDR_ZERO:       rd_mux = '0;
            ADDR_SCRATCH:    rd_mux = scratch;
            ADDR_STATUS:     rd_mux = {29'd0, error_flag, state == DONE, state == RUN};
            ADDR_THROTTLE:   rd_mux = {31'd0, throttle_en};
            ADDR_TARGET:     rd_mux = target;
            ADDR_RX_BYTES:   rd_mux = rx_bytes;
            ADDR_ERR_BEATS:  rd_mux = err_beats;
            ADDR_FIRST_ERR:  rd_mux = first_err;
            ADDR_RUN_CYCLES: rd_mux = run_cycles;
            default:         rd_mux = BAD_ADDR_WORD;
        endcase
    end

    always_ff @(posedge csi_clk_clk) begin
        if (!rsi_reset_reset_n) begin
            state             <= IDLE;
            avs_ctrl_readdata <= '0;
            scratch           <= '0;
            target            <= '0;
            throttle_en       <= 1'b0;
            rx_bytes          <= '0;
            err_beats         <= '0;
            first_err         <= '1;
            run_cycles        <= '0;
            beat_idx          <= '0;
            error_flag        <= 1'b0;
        end else begin
            avs_ctrl_readdata <= rd_mux;

            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    ADDR_SCRATCH:  scratch     <= avs_ctrl_writedata;
                    ADDR_TARGET:   target      <= avs_ctrl_writedata;
                    ADDR_THROTTLE: throttle_en <= avs_ctrl_writedata[0];
                    default: ;
                endcase
            end

            if (clear) begin
                state      <= IDLE;
                rx_bytes   <= '0;
                err_beats  <= '0;
                first_err  <= '1;
                run_cycles <= '0;
                beat_idx   <= '0;
                error_flag <= 1'b0;
            end else if (start_eff) begin
                state      <= RUN;
                rx_bytes   <= '0;
                err_beats  <= '0;
                first_err  <= '1;
                run_cycles <= '0;
                beat_idx   <= '0;
            end else if (state == RUN) begin
                run_cycles <= run_cycles + 32'd1;
                if (accept) begin
                    rx_bytes <= rx_next;
                    beat_idx <= beat_idx + 32'd1;
                    if (beat_bad) begin
                        error_flag <= 1'b1;
                        if (err_beats != '1) begin
                            err_beats <= err_beats + 32'd1;
                        end
                        if (first_err == '1) begin
                            first_err <= beat_idx;
                        end
                    end
                end
                if (done_now) begin
                    state <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_checker.sv
// Directed self-checking bench for avalon_st_checker with DATA_W=256.
module tb_avalon_st_checker;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   readdata;
    logic [31:0]   writedata = '0;
    logic [DW-1:0] data = '0;
    logic          valid = 1'b0;
    logic          ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    reg_vec_t vecs[$];

    always #5 clk = ~clk;

    avalon_st_checker #(.DATA_W(DW)) dut (
        .csi_clk_clk        (clk),
        .rsi_reset_reset_n  (rst_n),
        .avs_ctrl_address   (address),
        .avs_ctrl_read      (read),
        .avs_ctrl_write     (write),
        .avs_ctrl_readdata  (readdata),
        .avs_ctrl_writedata (writedata),
        .asi_data_data      (data),
        .asi_data_valid     (valid),
        .asi_data_ready     (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [DW-1:0] ramp(input int n);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/16; i++) begin
            r[16*i +: 16] = 16'((n * (DW/16) + i) % 65536);
        end
        return r;
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        d    = readdata;
        read = 1'b0;
    endtask

    task automatic add_vec(input logic [3:0] a, input logic [31:0] e, input string n);
        reg_vec_t v;
        v.addr = a;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic apply_vecs(input string tag);
        logic [31:0] d;
        foreach (vecs[k]) begin
            bus_read(vecs[k].addr, d);
            check({tag, "_", vecs[k].name}, d, vecs[k].exp);
        end
        vecs.delete();
    endtask

    task automatic load_reset_vecs();
        add_vec(4'd0,  32'ha51579e3, "id");
        add_vec(4'd1,  32'h00000100, "version");
        add_vec(4'd2,  32'h0,        "zero");
        add_vec(4'd3,  32'h0,        "scratch");
        add_vec(4'd4,  32'h0,        "status");
        add_vec(4'd6,  32'h0,        "throttle");
        add_vec(4'd8,  32'h0,        "target");
        add_vec(4'd9,  32'h0,        "rx_bytes");
        add_vec(4'd10, 32'h0,        "err_beats");
        add_vec(4'd11, 32'hffffffff, "first_err");
        add_vec(4'd12, 32'h0,        "run_cycles");
        add_vec(4'd7,  32'hdeadbeef, "unmapped7");
        add_vec(4'd13, 32'hdeadbeef, "unmapped13");
        add_vec(4'd15, 32'hdeadbeef, "unmapped15");
    endtask

    task automatic add_run_vecs(input logic [31:0] st, input logic [31:0] rx,
                                input logic [31:0] eb, input logic [31:0] fe,
                                input logic [31:0] cy);
        add_vec(4'd4,  st, "status");
        add_vec(4'd9,  rx, "rx_bytes");
        add_vec(4'd10, eb, "err_beats");
        add_vec(4'd11, fe, "first_err");
        add_vec(4'd12, cy, "run_cycles");
    endtask

    // Ideal ramp source starting in the first RUN cycle; ctrl_kind injects
    // 1 = start, 2 = start+clear, 3 = reset during cycle ctrl_at.
    task automatic run_stream(input string tag, input int nbeats, input bit thr,
                              input int bad_beat, input int ctrl_at, input int ctrl_kind,
                              output int cyc, output int acc);
        logic [15:0] lf;
        int src, rmis, budget;
        bit stopped, exp_r;
        lf = 16'hACE1;
        src = 0; cyc = 0; acc = 0; rmis = 0; stopped = 0;
        budget = nbeats * 4 + 64;
        valid = 1'b1;
        while (src < nbeats && cyc < budget && !stopped) begin
            data = ramp(src);
            if (src == bad_beat) data[63:48] = data[63:48] ^ 16'h0001;
            exp_r = !thr || lf[0];
            if (ready !== exp_r) rmis++;
            if (ready === 1'b1) begin
                src++;
                acc++;
            end
            if (cyc == ctrl_at) begin
                if (ctrl_kind == 3) begin
                    rst_n = 1'b0;
                end else begin
                    address   = 4'd5;
                    writedata = (ctrl_kind == 2) ? 32'd3 : 32'd1;
                    write     = 1'b1;
                end
            end
            lf = lfsr_model(lf);
            cyc++;
            @(negedge clk);
            write = 1'b0;
            if (ctrl_kind >= 2 && cyc == ctrl_at + 1) stopped = 1;
            if (ctrl_kind == 3 && stopped) begin
                check({tag, "_readdata_after_reset"}, readdata, 32'h0);
                rst_n = 1'b1;
            end
        end
        valid = 1'b0;
        check({tag, "_ready_pattern_mismatches"}, rmis, 0);
        if (!stopped) check({tag, "_stream_done"}, src, nbeats);
        check({tag, "_ready_low_after"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int cyc, acc, idle_ready;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_readdata", readdata, 32'h0);
        rst_n = 1'b1;

        load_reset_vecs();
        apply_vecs("por");

        bus_write(4'd3, 32'h12345678);
        add_vec(4'd3, 32'h12345678, "scratch_rb");
        apply_vecs("rw");

        // Data offered while IDLE must never be taken.
        idle_ready = 0;
        valid = 1'b1;
        data  = ramp(0);
        repeat (4) begin
            @(negedge clk);
            if (ready !== 1'b0) idle_ready++;
        end
        valid = 1'b0;
        check("idle_ready_cycles", idle_ready, 0);
        add_vec(4'd9, 32'h0, "rx_bytes");
        apply_vecs("idle");

        bus_write(4'd8, 32'h400);
        bus_write(4'd5, 32'h1);
        run_stream("clean", 32, 0, -1, -1, 0, cyc, acc);
        check("clean_ready_high_cycles", acc, 32);
        check("clean_model_cycles", cyc, 32);
        add_run_vecs(32'h2, 32'h400, 32'h0, 32'hffffffff, 32'd32);
        apply_vecs("clean");

        bus_write(4'd5, 32'h1);
        run_stream("corrupt", 32, 0, 5, -1, 0, cyc, acc);
        add_run_vecs(32'h6, 32'h400, 32'h1, 32'h5, 32'd32);
        apply_vecs("corrupt");

        bus_write(4'd5, 32'h2);
        add_run_vecs(32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0);
        apply_vecs("clear_idle");

        bus_write(4'd6, 32'h1);
        add_vec(4'd6, 32'h1, "throttle_rb");
        apply_vecs("thr");
        bus_write(4'd5, 32'h1);
        run_stream("throttle", 32, 1, -1, -1, 0, cyc, acc);
        check("throttle_accepts", acc, 32);
        check("throttle_slower", {31'd0, cyc > 32}, 32'd1);
        add_run_vecs(32'h2, 32'h400, 32'h0, 32'hffffffff, cyc);
        apply_vecs("throttle");
        bus_write(4'd6, 32'h0);

        bus_write(4'd5, 32'h1);
        run_stream("restart", 32, 0, -1, 10, 1, cyc, acc);
        add_run_vecs(32'h2, 32'h400, 32'h0, 32'hffffffff, 32'd32);
        apply_vecs("restart");

        bus_write(4'd5, 32'h1);
        run_stream("midclear", 32, 0, -1, 10, 2, cyc, acc);
        add_run_vecs(32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0);
        apply_vecs("midclear");

        bus_write(4'd8, 32'h0);
        bus_write(4'd5, 32'h1);
        check("tgt0_ready_first_cycle", {31'd0, ready}, 32'd1);
        @(negedge clk);
        check("tgt0_ready_after", {31'd0, ready}, 32'd0);
        add_run_vecs(32'h2, 32'h0, 32'h0, 32'hffffffff, 32'd1);
        apply_vecs("tgt0");

        bus_write(4'd3, 32'h0000cafe);
        bus_write(4'd6, 32'h1);
        bus_write(4'd8, 32'h400);
        bus_write(4'd5, 32'h1);
        run_stream("midreset", 32, 1, -1, 10, 3, cyc, acc);
        load_reset_vecs();
        apply_vecs("midreset");

        bus_write(4'd8, 32'd131104);
        bus_write(4'd5, 32'h1);
        run_stream("wrap", 4097, 0, -1, -1, 0, cyc, acc);
        add_run_vecs(32'h2, 32'd131104, 32'h0, 32'hffffffff, 32'd4097);
        apply_vecs("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
